// File: rtl/eigenloop_multi.sv
// eigenloop_multi
//   Power-iteration sequencer: for each of NUM_COMP seed vectors, repeatedly
//   asks an external recursion unit for v_k+1 = norm(M*v_k) and an external
//   convergence unit for a verdict, until converged or MAX_ITER iterations,
//   then stores v_k+1 and moves to the next seed. No FP arithmetic here;
//   values are 64-bit doubles passed through as raw bits.
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start, abort           run request (IDLE only), cancel to IDLE
//   seeds                  NUM_COMP x SIZE_N initial vectors, latched on start
//   rec_start/rec_vec      recursion request pulse and current vector v_k
//   rec_done/rec_result    recursion result strobe and v_k+1
//   conv_start/prev/next   convergence request pulse and compared vectors
//   conv_done/conv_ok      convergence verdict strobe and result
//   eig_vectors            stored eigenvectors
//   comp_idx, iter_count   current component, completed iterations
//   timeout                per-component "hit MAX_ITER" flags
//   busy, done             not-IDLE status, end-of-run pulse
module eigenloop_multi #(
    parameter int SIZE_N   = 8,
    parameter int NUM_COMP = 2,
    parameter int MAX_ITER = 100,
    parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic [NUM_COMP-1:0][SIZE_N-1:0][63:0]  seeds,
    output logic                                   rec_start,
    output logic [SIZE_N-1:0][63:0]                rec_vec,
    input  logic                                   rec_done,
    input  logic [SIZE_N-1:0][63:0]                rec_result,
    output logic                                   conv_start,
    output logic [SIZE_N-1:0][63:0]                conv_prev,
    output logic [SIZE_N-1:0][63:0]                conv_next,
    input  logic                                   conv_done,
    input  logic                                   conv_ok,
    output logic [NUM_COMP-1:0][SIZE_N-1:0][63:0]  eig_vectors,
    output logic [$clog2(NUM_COMP):0]              comp_idx,
    output logic [CNT_W-1:0]                       iter_count,
    output logic [NUM_COMP-1:0]                    timeout,
    output logic                                   busy,
    output logic                                   done
);

    localparam int CIDX_W = $clog2(NUM_COMP) + 1;
    // Array select width; a 1-entry array still needs a 1-bit index.
    localparam int SEL_W  = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_REC_REQ, S_REC_WAIT,
        S_CONV_REQ, S_CONV_WAIT, S_STORE, S_DONE
    } state_t;

    state_t                                r_state;
    state_t                                w_next;
    logic [NUM_COMP-1:0][SIZE_N-1:0][63:0] r_seeds;
    logic [NUM_COMP-1:0][SIZE_N-1:0][63:0] r_eig;
    logic [SIZE_N-1:0][63:0]               r_vk;
    logic [SIZE_N-1:0][63:0]               r_vnext;
    logic [CIDX_W-1:0]                     r_comp;
    logic [CNT_W-1:0]                      r_iter;
    logic [NUM_COMP-1:0]                   r_timeout;
    logic [SEL_W-1:0]                      w_sel;
    logic                                  w_last_iter;
    logic                                  w_last_comp;
    logic                                  w_rec_start;
    logic                                  w_conv_start;
    logic                                  w_done;

    assign w_sel       = r_comp[SEL_W-1:0];
    assign w_last_iter = (r_iter == CNT_W'(MAX_ITER - 1));
    assign w_last_comp = (r_comp == CIDX_W'(NUM_COMP - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_rec_start  = 1'b0;
        w_conv_start = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE:      if (start && !abort) w_next = S_LOAD;
            S_LOAD:      w_next = S_REC_REQ;
            S_REC_REQ: begin
                w_rec_start = 1'b1;
                w_next      = S_REC_WAIT;
            end
            S_REC_WAIT:  if (rec_done) w_next = S_CONV_REQ;
            S_CONV_REQ: begin
                w_conv_start = 1'b1;
                w_next       = S_CONV_WAIT;
            end
            S_CONV_WAIT: if (conv_done) w_next = (conv_ok || w_last_iter) ? S_STORE : S_REC_REQ;
            S_STORE:     w_next = w_last_comp ? S_DONE : S_LOAD;
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default:     w_next = S_IDLE;
        endcase
        // abort overrides every transition, including same-cycle strobes
        if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seeds   <= '0;
            r_eig     <= '0;
            r_vk      <= '0;
            r_vnext   <= '0;
            r_comp    <= '0;
            r_iter    <= '0;
            r_timeout <= '0;
        end else if (r_state == S_IDLE) begin
            if (start && !abort) begin
                r_seeds   <= seeds;
                r_eig     <= '0;
                r_timeout <= '0;
                r_comp    <= '0;
            end
        end else if (!abort) begin
            case (r_state)
                S_LOAD: begin
                    r_vk   <= r_seeds[w_sel];
                    r_iter <= '0;
                end
                S_REC_WAIT: if (rec_done) r_vnext <= rec_result;
                S_CONV_WAIT: begin
                    if (conv_done && !conv_ok) begin
                        if (w_last_iter) begin
                            r_timeout[w_sel] <= 1'b1;
                        end else begin
                            r_vk   <= r_vnext;
                            r_iter <= r_iter + CNT_W'(1);
                        end
                    end
                end
                S_STORE: begin
                    r_eig[w_sel] <= r_vnext;
                    if (!w_last_comp) r_comp <= r_comp + CIDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign rec_start   = w_rec_start;
    assign conv_start  = w_conv_start;
    assign done        = w_done;
    assign busy        = (r_state != S_IDLE);
    assign rec_vec     = r_vk;
    assign conv_prev   = r_vk;
    assign conv_next   = r_vnext;
    assign eig_vectors = r_eig;
    assign comp_idx    = r_comp;
    assign iter_count  = r_iter;
    assign timeout     = r_timeout;

endmodule
